test_status_monitor: RTL and testbench
======================================

TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

Interface
REQ-001 Parameter NUM_CH, default 4: number of monitored status channels, 1..16.
REQ-002 Parameter DATA_WIDTH, default 32: width of each status register.
REQ-003 Parameter PASS_CODE, default 'hFF: channel-pass value.
REQ-004 Parameter FAIL_CODE, default 'hFE: channel-fail value.
REQ-005 Parameter CNT_WIDTH, default 32: cycle counter and timeout width.
REQ-006 Single clock and reset, fixed: clk sampled on rising edge; rst_n asynchronous active-low.
REQ-007 Ports, in order:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- start_i  in  1  one-cycle pulse arming the monitor.
- clear_i  in  1  returns the monitor to IDLE.
- ch_en_i  in  NUM_CH  per-channel enable mask, sampled on start.
- ch_reg_i  in  NUM_CH x DATA_WIDTH  status register values.
- timeout_i  in  CNT_WIDTH  cycle limit, sampled on start; 0 means no limit.
- done_o  out  1  test finished, all enabled channels passed.
- fail_o  out  1  test finished, at least one channel failed.
- timeout_o  out  1  limit reached before all enabled channels finished.
- exit_code_o  out  8  completion code.
- ch_done_o  out  NUM_CH  sticky per-channel finished flags.
- cycle_cnt_o  out  CNT_WIDTH  cycles elapsed in RUN.
- heartbeat_o  out  1  progress pulse (see Configuration).

Function
REQ-008 States: IDLE, RUN, DONE, TIMEOUT.
REQ-009 Transition IDLE->RUN:
- occurs on start_i.
- latches ch_en_i and timeout_i.
- clears the sticky flags and the counter.
- if the latched mask is all-zero, goes straight to DONE next cycle.
REQ-010 RUN, each cycle:
- an enabled channel whose ch_reg_i equals PASS_CODE or FAIL_CODE sets its sticky done flag.
- a FAIL_CODE match also sets its sticky fail flag.
- flags never clear in RUN.
REQ-011 RUN: cycle_cnt_o increments by 1 per cycle and saturates at all-ones; no wrap.
REQ-012 RUN->DONE when all enabled sticky done flags are set, including flags set in the current cycle; transition is registered, latency 1 cycle from the final matching value.
REQ-013 RUN->TIMEOUT when timeout is nonzero and cycle_cnt_o equals timeout-1 in the same cycle that completion is not reached; completion wins when both happen together.
REQ-014 Disabled channels are ignored; their ch_done_o stays 0.
REQ-015 In DONE:
- done_o=1 when no fail flag is set; fail_o=1 when any fail flag is set.
- exit_code_o = 0 on pass, otherwise 1 + index of the lowest failing channel.
REQ-016 In TIMEOUT: timeout_o=1 and exit_code_o='hFF; done_o and fail_o stay 0.
REQ-017 DONE and TIMEOUT hold all outputs until clear_i, then go to IDLE; start_i is ignored outside IDLE.
REQ-018 clear_i in RUN aborts to IDLE next cycle; clear_i wins over start_i in the same cycle.
REQ-019 In IDLE: status outputs are 0; cycle_cnt_o holds the last value.

Reset
REQ-020 rst_n low asynchronously forces:
- state IDLE.
- all outputs 0.
- latched mask and timeout 0.
- sticky flags 0.
REQ-021 Reset asserted mid-RUN discards the test in progress; no completion is reported after release.

Configuration
REQ-022 Macro TEST_MON_HEARTBEAT_EN:
- defined: heartbeat_o is a one-cycle pulse every 2**HB_SHIFT RUN cycles (localparam HB_SHIFT=10), i.e. when cycle_cnt_o[HB_SHIFT-1:0] wraps to 0 after increment.
- undefined: heartbeat_o is tied 0 and no heartbeat logic is present.

Structure
REQ-023 Package test_mon_pkg holds:
- the state enum.
- EXIT_PASS=0 and EXIT_TIMEOUT='hFF.
- HB_SHIFT.
REQ-024 Sub-module test_mon_channel, instantiated NUM_CH times, holds the match compare and the sticky done/fail flags of one channel.

Verification
REQ-025 NUM_CH=4, mask 'b1111, timeout 0; channels write 'hFF at cycles 3,5,7,9 -> done_o=1 at cycle 10, exit_code_o=0, ch_done_o='hF.
REQ-026 Mask 'b0101; ch2 writes 'hFE, ch0 writes 'hFF; ch1 and ch3 write 'hFE -> fail_o=1, exit_code_o=3, ch_done_o='b0101.
REQ-027 timeout_i=20; only ch0 of mask 'b0011 passes -> timeout_o=1 exactly 20 cycles after start, exit_code_o='hFF.
REQ-028 timeout_i=20; last channel passes in cycle 19 of RUN -> done_o=1, timeout_o=0.
REQ-029 rst_n pulsed low mid-RUN, then clear_i and start_i in the same cycle -> outputs 0 during reset; state stays IDLE after the same-cycle clear/start.
REQ-030 With TEST_MON_HEARTBEAT_EN defined, 3000 RUN cycles -> 2 heartbeat pulses, at counts 1024 and 2048; without the macro -> heartbeat_o constant 0.

Source files
------------

// File: rtl/test_mon_pkg.sv
// Shared definitions for the test status monitor.
//   mon_state_e  : controller state encoding
//   EXIT_PASS    : exit code reported when every enabled channel passed
//   EXIT_TIMEOUT : exit code reported when the cycle limit expired
//   HB_SHIFT     : log2 of the heartbeat period in RUN cycles
//                  (used only when TEST_MON_HEARTBEAT_EN is defined)
package test_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  localparam logic [7:0] EXIT_PASS    = 8'h00;
  localparam logic [7:0] EXIT_TIMEOUT = 8'hFF;
  localparam int         HB_SHIFT     = 10;

endpackage

// File: rtl/test_mon_channel.sv
// One monitored status channel: compares the channel's status register
// against the pass/fail codes and keeps sticky done/fail flags.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of both sticky flags
//   upd        : monitor is in RUN and may update flags this cycle
//   en         : channel enabled in the latched mask
//   reg_val    : channel status register value
//   done_nxt   : done flag including a match in the current cycle
//   done       : sticky done flag
//   fail       : sticky fail flag
module test_mon_channel #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PASS_CODE  = 'hFF,
  parameter logic [DATA_WIDTH-1:0] FAIL_CODE  = 'hFE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  upd,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] reg_val,
  output logic                  done_nxt,
  output logic                  done,
  output logic                  fail
);

  logic pass_hit;
  logic fail_hit;
  logic hit;

  assign pass_hit = (reg_val == PASS_CODE);
  assign fail_hit = (reg_val == FAIL_CODE);
  assign hit      = upd & en & (pass_hit | fail_hit);

  // Completion in the top looks at this so a match in the final cycle
  // counts without waiting for the flag to register.
  assign done_nxt = done | hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      fail <= 1'b0;
    end else if (clr) begin
      done <= 1'b0;
      fail <= 1'b0;
    end else if (hit) begin
      done <= 1'b1;
      if (fail_hit) begin
        fail <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// Test status monitor: watches NUM_CH status registers after a start pulse
// and reports pass, fail (with lowest failing channel) or timeout.
// Optional feature macro: TEST_MON_HEARTBEAT_EN (heartbeat pulse every
// 2**HB_SHIFT RUN cycles; heartbeat_o tied low when undefined).
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   start_i      : arms the monitor (IDLE only)
//   clear_i      : returns to IDLE, wins over start_i
//   ch_en_i      : channel enable mask, latched on start
//   ch_reg_i     : per-channel status register values
//   timeout_i    : RUN cycle limit, latched on start, 0 = unlimited
//   done_o       : finished, all enabled channels passed
//   fail_o       : finished, at least one channel failed
//   timeout_o    : cycle limit expired first
//   exit_code_o  : 0 pass, 1+lowest failing channel, 'hFF timeout
//   ch_done_o    : sticky per-channel finished flags
//   cycle_cnt_o  : RUN cycles elapsed (saturating, held outside RUN)
//   heartbeat_o  : progress pulse
//
// state      | meaning
// ST_IDLE    | waiting for start_i, status outputs 0
// ST_RUN     | sampling channels, counting cycles
// ST_DONE    | all enabled channels finished, pass/fail held until clear_i
// ST_TIMEOUT | limit hit before completion, held until clear_i
module test_status_monitor
  import test_mon_pkg::*;
#(
  parameter int                    NUM_CH     = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PASS_CODE  = 'hFF,
  parameter logic [DATA_WIDTH-1:0] FAIL_CODE  = 'hFE,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start_i,
  input  logic                                clear_i,
  input  logic [NUM_CH-1:0]                   ch_en_i,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   ch_reg_i,
  input  logic [CNT_WIDTH-1:0]                timeout_i,
  output logic                                done_o,
  output logic                                fail_o,
  output logic                                timeout_o,
  output logic [7:0]                          exit_code_o,
  output logic [NUM_CH-1:0]                   ch_done_o,
  output logic [CNT_WIDTH-1:0]                cycle_cnt_o,
  output logic                                heartbeat_o
);

  mon_state_e           state_q;
  mon_state_e           state_d;
  logic [NUM_CH-1:0]    en_q;
  logic [CNT_WIDTH-1:0] timeout_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [NUM_CH-1:0]    done_nxt;
  logic [NUM_CH-1:0]    done_q;
  logic [NUM_CH-1:0]    fail_q;
  logic                 start_go;
  logic                 run_upd;
  logic                 flag_clr;
  logic                 cnt_sat;
  logic                 all_done;
  logic                 limit_hit;
  logic                 any_fail;
  logic [7:0]           fail_code;

  assign start_go  = (state_q == ST_IDLE) && start_i && !clear_i;
  assign run_upd   = (state_q == ST_RUN) && !clear_i;
  assign flag_clr  = start_go || clear_i;
  assign cnt_sat   = (cnt_q == '1);
  assign cnt_inc   = cnt_q + 1'b1;
  // Disabled channels count as finished, so an empty mask completes at once.
  assign all_done  = &(done_nxt | ~en_q);
  assign limit_hit = (timeout_q != '0) && (cnt_q == timeout_q - 1'b1);
  assign any_fail  = |fail_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    test_mon_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .PASS_CODE  (PASS_CODE),
      .FAIL_CODE  (FAIL_CODE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (flag_clr),
      .upd      (run_upd),
      .en       (en_q[g]),
      .reg_val  (ch_reg_i[g]),
      .done_nxt (done_nxt[g]),
      .done     (done_q[g]),
      .fail     (fail_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      en_q      <= '0;
      timeout_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        en_q      <= ch_en_i;
        timeout_q <= timeout_i;
        cnt_q     <= '0;
      end else if (run_upd && !cnt_sat) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  // Lowest failing channel wins, so scan from the top down.
  always_comb begin
    fail_code = 8'h00;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_q[i]) begin
        fail_code = 8'(i + 1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    done_o      = 1'b0;
    fail_o      = 1'b0;
    timeout_o   = 1'b0;
    exit_code_o = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Completion takes priority over the limit in the same cycle.
        if (clear_i) begin
          state_d = ST_IDLE;
        end else if (all_done) begin
          state_d = ST_DONE;
        end else if (limit_hit) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DONE: begin
        done_o      = !any_fail;
        fail_o      = any_fail;
        exit_code_o = any_fail ? fail_code : EXIT_PASS;
        if (clear_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_TIMEOUT: begin
        timeout_o   = 1'b1;
        exit_code_o = EXIT_TIMEOUT;
        if (clear_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ch_done_o   = done_q;
  assign cycle_cnt_o = cnt_q;

`ifdef TEST_MON_HEARTBEAT_EN
  logic hb_q;

  // Pulse in the cycle where the counter has just wrapped its low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q <= 1'b0;
    end else begin
      hb_q <= run_upd && !cnt_sat && (cnt_inc[HB_SHIFT-1:0] == '0);
    end
  end

  assign heartbeat_o = hb_q;
`else
  assign heartbeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
module tb_test_status_monitor;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic              clear_i;
  logic [3:0]        ch_en_i;
  logic [3:0][31:0]  ch_reg_i;
  logic [31:0]       timeout_i;
  logic              done_o;
  logic              fail_o;
  logic              timeout_o;
  logic [7:0]        exit_code_o;
  logic [3:0]        ch_done_o;
  logic [31:0]       cycle_cnt_o;
  logic              heartbeat_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  test_status_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .clear_i     (clear_i),
    .ch_en_i     (ch_en_i),
    .ch_reg_i    (ch_reg_i),
    .timeout_i   (timeout_i),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .timeout_o   (timeout_o),
    .exit_code_o (exit_code_o),
    .ch_done_o   (ch_done_o),
    .cycle_cnt_o (cycle_cnt_o),
    .heartbeat_o (heartbeat_o)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [3:0] mask, input logic [31:0] to);
    ch_en_i   = mask;
    timeout_i = to;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    ch_reg_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0;
    ch_en_i = '0; ch_reg_i = '0; timeout_i = '0;
    #12;
    n_total++;
    if ({done_o, fail_o, timeout_o, heartbeat_o} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {done_o, fail_o, timeout_o, heartbeat_o}); else n_pass++;
    n_total++;
    if (exit_code_o !== 8'h00) $display("FAIL reset_exit got %h want 00", exit_code_o); else n_pass++;
    n_total++;
    if (ch_done_o !== 4'h0) $display("FAIL reset_ch_done got %h want 0", ch_done_o); else n_pass++;
    n_total++;
    if (cycle_cnt_o !== 32'd0) $display("FAIL reset_cnt got %0d want 0", cycle_cnt_o); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_pass();
    do_start(4'hF, 32'd0);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) ch_reg_i[0] = 32'hFF;
      if (c == 5) ch_reg_i[1] = 32'hFF;
      if (c == 7) ch_reg_i[2] = 32'hFF;
      if (c == 9) ch_reg_i[3] = 32'hFF;
      n_total++;
      if (done_o !== 1'b0 || cycle_cnt_o !== 32'(c)) $display("FAIL pass_run c=%0d got done=%b cnt=%0d want done=0 cnt=%0d", c, done_o, cycle_cnt_o, c); else n_pass++;
      tick();
    end
    n_total++;
    if (done_o !== 1'b1 || fail_o !== 1'b0) $display("FAIL pass_done got done=%b fail=%b want 1 0", done_o, fail_o); else n_pass++;
    n_total++;
    if (exit_code_o !== 8'h00) $display("FAIL pass_exit got %h want 00", exit_code_o); else n_pass++;
    n_total++;
    if (ch_done_o !== 4'hF) $display("FAIL pass_ch_done got %h want F", ch_done_o); else n_pass++;
    n_total++;
    if (cycle_cnt_o !== 32'd10) $display("FAIL pass_cnt got %0d want 10", cycle_cnt_o); else n_pass++;
    // start ignored while in DONE
    do_start(4'h1, 32'd0);
    tick(2);
    n_total++;
    if (done_o !== 1'b1 || cycle_cnt_o !== 32'd10) $display("FAIL done_hold got done=%b cnt=%0d want 1 10", done_o, cycle_cnt_o); else n_pass++;
    do_clear();
    n_total++;
    if (done_o !== 1'b0 || ch_done_o !== 4'h0 || cycle_cnt_o !== 32'd10) $display("FAIL clear_idle got done=%b ch=%h cnt=%0d want 0 0 10", done_o, ch_done_o, cycle_cnt_o); else n_pass++;
  endtask

  task automatic test_fail();
    do_start(4'b0101, 32'd0);
    ch_reg_i[1] = 32'hFE; ch_reg_i[2] = 32'hFE; ch_reg_i[3] = 32'hFE;
    tick();
    n_total++;
    if (ch_done_o !== 4'b0100 || fail_o !== 1'b0 || done_o !== 1'b0) $display("FAIL fail_partial got ch=%b fail=%b done=%b want 0100 0 0", ch_done_o, fail_o, done_o); else n_pass++;
    ch_reg_i[0] = 32'hFF;
    tick();
    n_total++;
    if (fail_o !== 1'b1 || done_o !== 1'b0) $display("FAIL fail_flag got fail=%b done=%b want 1 0", fail_o, done_o); else n_pass++;
    n_total++;
    if (exit_code_o !== 8'd3) $display("FAIL fail_exit got %0d want 3", exit_code_o); else n_pass++;
    n_total++;
    if (ch_done_o !== 4'b0101) $display("FAIL fail_ch_done got %b want 0101", ch_done_o); else n_pass++;
    do_clear();
  endtask

  task automatic test_timeout();
    do_start(4'b0011, 32'd20);
    ch_reg_i[0] = 32'hFF;
    for (int c = 0; c < 20; c++) begin
      n_total++;
      if (timeout_o !== 1'b0) $display("FAIL to_early c=%0d got %b want 0", c, timeout_o); else n_pass++;
      tick();
    end
    n_total++;
    if (timeout_o !== 1'b1 || done_o !== 1'b0 || fail_o !== 1'b0) $display("FAIL to_flag got to=%b done=%b fail=%b want 1 0 0", timeout_o, done_o, fail_o); else n_pass++;
    n_total++;
    if (exit_code_o !== 8'hFF) $display("FAIL to_exit got %h want FF", exit_code_o); else n_pass++;
    n_total++;
    if (ch_done_o !== 4'b0001 || cycle_cnt_o !== 32'd20) $display("FAIL to_state got ch=%b cnt=%0d want 0001 20", ch_done_o, cycle_cnt_o); else n_pass++;
    do_clear();
  endtask

  task automatic test_timeout_race();
    do_start(4'b0011, 32'd20);
    ch_reg_i[0] = 32'hFF;
    tick(19);
    ch_reg_i[1] = 32'hFF;
    tick();
    n_total++;
    if (done_o !== 1'b1 || timeout_o !== 1'b0) $display("FAIL race got done=%b to=%b want 1 0", done_o, timeout_o); else n_pass++;
    do_clear();
  endtask

  task automatic test_empty_mask();
    do_start(4'b0000, 32'd5);
    ch_reg_i = {4{32'hFE}};
    n_total++;
    if (done_o !== 1'b0) $display("FAIL empty_run got %b want 0", done_o); else n_pass++;
    tick();
    n_total++;
    if (done_o !== 1'b1 || exit_code_o !== 8'h00 || ch_done_o !== 4'h0) $display("FAIL empty_done got done=%b exit=%h ch=%h want 1 00 0", done_o, exit_code_o, ch_done_o); else n_pass++;
    do_clear();
  endtask

  task automatic test_abort();
    do_start(4'hF, 32'd0);
    tick(3);
    do_clear();
    n_total++;
    if ({done_o, fail_o, timeout_o} !== 3'b000 || cycle_cnt_o !== 32'd3) $display("FAIL abort got flags=%b cnt=%0d want 000 3", {done_o, fail_o, timeout_o}, cycle_cnt_o); else n_pass++;
    ch_reg_i = {4{32'hFF}};
    tick(2);
    n_total++;
    if (done_o !== 1'b0 || ch_done_o !== 4'h0) $display("FAIL abort_idle got done=%b ch=%h want 0 0", done_o, ch_done_o); else n_pass++;
    ch_reg_i = '0;
  endtask

  task automatic test_reset_mid_run();
    do_start(4'hF, 32'd0);
    tick(2);
    ch_reg_i[0] = 32'hFF;
    tick();
    n_total++;
    if (ch_done_o !== 4'b0001) $display("FAIL mid_pre got %b want 0001", ch_done_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({done_o, fail_o, timeout_o} !== 3'b000 || ch_done_o !== 4'h0 || cycle_cnt_o !== 32'd0 || exit_code_o !== 8'h00) $display("FAIL mid_reset got flags=%b ch=%h cnt=%0d exit=%h want 0", {done_o, fail_o, timeout_o}, ch_done_o, cycle_cnt_o, exit_code_o); else n_pass++;
    tick(2);
    rst_n = 1'b1;
    ch_reg_i = {4{32'hFF}};
    clear_i = 1'b1; start_i = 1'b1; ch_en_i = 4'hF;
    tick();
    clear_i = 1'b0; start_i = 1'b0;
    tick(3);
    n_total++;
    if (done_o !== 1'b0 || cycle_cnt_o !== 32'd0 || ch_done_o !== 4'h0) $display("FAIL mid_idle got done=%b cnt=%0d ch=%h want 0 0 0", done_o, cycle_cnt_o, ch_done_o); else n_pass++;
    ch_reg_i = '0;
  endtask

  task automatic test_heartbeat();
    int pulses;
    int exp_pulses;
    pulses = 0;
`ifdef TEST_MON_HEARTBEAT_EN
    exp_pulses = 2;
`else
    exp_pulses = 0;
`endif
    do_start(4'b0001, 32'd0);
    for (int c = 0; c < 3000; c++) begin
      if (heartbeat_o === 1'b1) begin
        pulses++;
        n_total++;
        if (cycle_cnt_o !== 32'(1024 * pulses)) $display("FAIL hb_pos got cnt=%0d want %0d", cycle_cnt_o, 1024 * pulses); else n_pass++;
      end
      tick();
    end
    n_total++;
    if (pulses !== exp_pulses) $display("FAIL hb_count got %0d want %0d", pulses, exp_pulses); else n_pass++;
    do_clear();
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_fail();
    test_timeout();
    test_timeout_race();
    test_empty_mask();
    test_abort();
    test_reset_mid_run();
    test_heartbeat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
